stb_drain_ctrl: RTL and testbench
=================================

STB_DRAIN_CTRL -- requirements
Module: stb_drain_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 32, address width; DATA_WIDTH, default 32, data width; BYTE_SEL_WIDTH, default 4, byte-select width; MAX_DEFER, default 8, maximum cycles a drain may yield to loads; ACK_TIMEOUT, default 64, cycles before an ack-timeout error is flagged.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- stb_empty  in  1  store buffer empty
- stb_head_addr  in  ADDR_WIDTH  head entry address
- stb_head_wdata  in  DATA_WIDTH  head entry data
- stb_head_sel_byte  in  BYTE_SEL_WIDTH  head entry byte select
- stb_r_en  out  1  pop head entry from store buffer
- lsu_load_pending  in  1  LSU load wants the dcache port
- flush_req  in  1  level; drain all entries (fence)
- flush_done  out  1  flush complete
- stb2dcache_addr  out  ADDR_WIDTH  write address
- stb2dcache_wdata  out  DATA_WIDTH  write data
- stb2dcache_sel_byte  out  BYTE_SEL_WIDTH  write byte select
- stb2dcache_w_en  out  1  write enable
- stb2dcache_req  out  1  dcache request
- dcache2stb_ack  in  1  dcache accepted the write
- stb_drain_busy  out  1  a write is outstanding
- stb_drain_err  out  1  sticky ack-timeout flag

Function
REQ-004 FSM states SHALL be IDLE and WAIT_ACK only.
REQ-005 Issue condition in IDLE SHALL be: !stb_empty AND (!lsu_load_pending OR flush_req OR defer_cnt == MAX_DEFER).
REQ-006 On an issue-condition edge, the block SHALL register the head addr/wdata/sel_byte into the stb2dcache_* outputs, set req=w_en=1, and enter WAIT_ACK, so req is visible one cycle after the condition.
REQ-007 In WAIT_ACK, req, w_en, addr, wdata and sel_byte SHALL be held stable until ack.
REQ-008 stb_r_en SHALL be combinational: stb2dcache_req AND dcache2stb_ack; it is a one-cycle pulse per accepted write.
REQ-009 On the ack edge, the block SHALL clear req and w_en, clear addr, wdata and sel_byte to 0, and return to IDLE; a new issue is permitted from the following cycle, giving a minimum of 2 cycles per store.
REQ-010 dcache2stb_ack SHALL be ignored while req=0, and an ack in the first req cycle SHALL be accepted.
REQ-011 defer_cnt, width $clog2(MAX_DEFER+1), SHALL increment in IDLE while !stb_empty AND lsu_load_pending AND !flush_req AND defer_cnt < MAX_DEFER.
REQ-012 defer_cnt SHALL clear to 0 on issue or whenever stb_empty=1, and SHALL saturate at MAX_DEFER.
REQ-013 MAX_DEFER=0 SHALL mean loads never delay a drain.
REQ-014 ack_cnt SHALL count cycles in WAIT_ACK without ack and clear on ack.
REQ-015 When ack_cnt reaches ACK_TIMEOUT, stb_drain_err SHALL set and remain set until rst; the request SHALL stay held (no abort, no pop), and ack_cnt SHALL saturate.
REQ-016 stb_drain_busy SHALL equal (state == WAIT_ACK).
REQ-017 flush_done SHALL be combinational: flush_req AND stb_empty AND state == IDLE.
REQ-018 Deasserting flush_req mid-drain SHALL let the outstanding write complete normally, after which load deferral resumes.
REQ-019 stb_empty rising while in WAIT_ACK SHALL have no effect on the outstanding write.

Reset
REQ-020 On rst=1 at a clock edge: state=IDLE; defer_cnt=0; ack_cnt=0; stb2dcache_req=0; w_en=0; addr, wdata and sel_byte=0; stb_drain_err=0.
REQ-021 Reset during WAIT_ACK SHALL drop req in the next cycle with no pop; the entry remains in the store buffer.
REQ-022 Outputs SHALL be defined from the first edge with rst=1.

Verification
REQ-023 Single store: head=0x1000/0xDEADBEEF/0xF, stb_empty 1->0, ack on the 3rd req cycle -> req high for 3 cycles with stable data, one stb_r_en pulse, req=0 the next cycle.
REQ-024 Back-to-back: 4 entries, ack tied high -> 4 writes at a 2-cycle cadence, 4 stb_r_en pulses, then IDLE.
REQ-025 Load priority: lsu_load_pending=1 held, MAX_DEFER=8, one entry -> req rises exactly 9 cycles after stb_empty falls; repeat with load dropping after 3 cycles -> req rises 1 cycle after the drop.
REQ-026 Flush: 3 entries, flush_req=1, lsu_load_pending=1 -> no deferral; flush_done rises in the cycle after the 3rd ack, when stb_empty=1.
REQ-027 Timeout: ack withheld 70 cycles with ACK_TIMEOUT=64 -> stb_drain_err=1 from cycle 64, req still held; ack later -> normal pop, err stays 1.
REQ-028 Reset mid-WAIT_ACK -> next cycle req=0, stb_r_en never pulses, all outputs equal the REQ-020 values.

Source files
------------

// File: rtl/stb_drain_ctrl.sv
// rtl/stb_drain_ctrl.sv - store buffer drain controller
// Pops store buffer head entries into the dcache, yielding to loads for a bounded time.
module stb_drain_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_SEL_WIDTH = 4,
    parameter int MAX_DEFER      = 8,
    parameter int ACK_TIMEOUT    = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stb_empty,
    input  logic [ADDR_WIDTH-1:0]     stb_head_addr,
    input  logic [DATA_WIDTH-1:0]     stb_head_wdata,
    input  logic [BYTE_SEL_WIDTH-1:0] stb_head_sel_byte,
    output logic                      stb_r_en,
    input  logic                      lsu_load_pending,
    input  logic                      flush_req,
    output logic                      flush_done,
    output logic [ADDR_WIDTH-1:0]     stb2dcache_addr,
    output logic [DATA_WIDTH-1:0]     stb2dcache_wdata,
    output logic [BYTE_SEL_WIDTH-1:0] stb2dcache_sel_byte,
    output logic                      stb2dcache_w_en,
    output logic                      stb2dcache_req,
    input  logic                      dcache2stb_ack,
    output logic                      stb_drain_busy,
    output logic                      stb_drain_err
);

    // Counters keep at least one bit so a zero limit still elaborates.
    localparam int DEFER_W = (MAX_DEFER > 0) ? $clog2(MAX_DEFER + 1) : 1;
    localparam int ACK_W   = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [DEFER_W-1:0] DEFER_MAX = DEFER_W'(MAX_DEFER);
    localparam logic [ACK_W-1:0]   ACK_MAX   = ACK_W'(ACK_TIMEOUT);

    typedef enum logic {
        IDLE,
        WAIT_ACK
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [DEFER_W-1:0] defer_cnt;
    logic [DEFER_W-1:0] defer_cnt_next;
    logic [ACK_W-1:0]   ack_cnt;
    logic [ACK_W-1:0]   ack_cnt_next;
    logic               err_next;
    logic               issue;
    logic               accept;

    assign accept         = stb2dcache_req & dcache2stb_ack;
    assign stb_r_en       = accept;
    assign stb_drain_busy = (state == WAIT_ACK);
    assign flush_done     = flush_req & stb_empty & (state == IDLE);

    always_comb begin
        state_next     = state;
        defer_cnt_next = defer_cnt;
        ack_cnt_next   = ack_cnt;
        err_next       = stb_drain_err;
        issue          = 1'b0;
        case (state)
            IDLE: begin
                issue        = !stb_empty &&
                               (!lsu_load_pending || flush_req || defer_cnt == DEFER_MAX);
                ack_cnt_next = '0;
                if (stb_empty || issue)
                    defer_cnt_next = '0;
                else if (lsu_load_pending && !flush_req && defer_cnt < DEFER_MAX)
                    defer_cnt_next = defer_cnt + 1'b1;
                if (issue)
                    state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (stb_empty)
                    defer_cnt_next = '0;
                if (accept) begin
                    ack_cnt_next = '0;
                    state_next   = IDLE;
                end else begin
                    // The request is never abandoned; the timeout only raises a sticky flag.
                    if (ack_cnt != ACK_MAX)
                        ack_cnt_next = ack_cnt + 1'b1;
                    if (ack_cnt_next == ACK_MAX)
                        err_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            defer_cnt           <= '0;
            ack_cnt             <= '0;
            stb_drain_err       <= 1'b0;
            stb2dcache_req      <= 1'b0;
            stb2dcache_w_en     <= 1'b0;
            stb2dcache_addr     <= '0;
            stb2dcache_wdata    <= '0;
            stb2dcache_sel_byte <= '0;
        end else begin
            state         <= state_next;
            defer_cnt     <= defer_cnt_next;
            ack_cnt       <= ack_cnt_next;
            stb_drain_err <= err_next;
            if (accept) begin
                stb2dcache_req      <= 1'b0;
                stb2dcache_w_en     <= 1'b0;
                stb2dcache_addr     <= '0;
                stb2dcache_wdata    <= '0;
                stb2dcache_sel_byte <= '0;
            end else if (issue) begin
                stb2dcache_req      <= 1'b1;
                stb2dcache_w_en     <= 1'b1;
                stb2dcache_addr     <= stb_head_addr;
                stb2dcache_wdata    <= stb_head_wdata;
                stb2dcache_sel_byte <= stb_head_sel_byte;
            end
        end
    end

endmodule

// File: tb/tb_stb_drain_ctrl.sv
// tb/tb_stb_drain_ctrl.sv - scoreboard bench for stb_drain_ctrl
module tb_stb_drain_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb_empty;
    logic [31:0] stb_head_addr;
    logic [31:0] stb_head_wdata;
    logic [3:0]  stb_head_sel_byte;
    logic        stb_r_en;
    logic        lsu_load_pending;
    logic        flush_req;
    logic        flush_done;
    logic [31:0] stb2dcache_addr;
    logic [31:0] stb2dcache_wdata;
    logic [3:0]  stb2dcache_sel_byte;
    logic        stb2dcache_w_en;
    logic        stb2dcache_req;
    logic        dcache2stb_ack;
    logic        stb_drain_busy;
    logic        stb_drain_err;

    stb_drain_ctrl #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .BYTE_SEL_WIDTH(4),
        .MAX_DEFER(8), .ACK_TIMEOUT(64)
    ) dut (
        .clk(clk), .rst(rst), .stb_empty(stb_empty),
        .stb_head_addr(stb_head_addr), .stb_head_wdata(stb_head_wdata),
        .stb_head_sel_byte(stb_head_sel_byte), .stb_r_en(stb_r_en),
        .lsu_load_pending(lsu_load_pending), .flush_req(flush_req), .flush_done(flush_done),
        .stb2dcache_addr(stb2dcache_addr), .stb2dcache_wdata(stb2dcache_wdata),
        .stb2dcache_sel_byte(stb2dcache_sel_byte), .stb2dcache_w_en(stb2dcache_w_en),
        .stb2dcache_req(stb2dcache_req), .dcache2stb_ack(dcache2stb_ack),
        .stb_drain_busy(stb_drain_busy), .stb_drain_err(stb_drain_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
    } ent_t;

    ent_t sbuf[$];
    ent_t expq[$];
    int   rises[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   req_run = 0;
    int   ack_after = 0;
    int   pops = 0;
    int   req_hi = 0;
    int   err_first = -1;
    int   fd_first = -1;
    int   t0 = 0;
    logic prev_req = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, want);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        ent_t e;
        e = '{addr: a, data: d, sel: s};
        sbuf.push_back(e);
        expq.push_back(e);
    endtask

    task automatic new_test();
        rises.delete();
        pops      = 0;
        req_hi    = 0;
        err_first = -1;
        fd_first  = -1;
        t0        = cyc;
    endtask

    // One clock cycle: drive inputs, sample at the falling edge, retire pops after the rising edge.
    task automatic tick();
        logic popped;
        logic req_now;
        stb_empty = (sbuf.size() == 0);
        if (sbuf.size() != 0) begin
            stb_head_addr     = sbuf[0].addr;
            stb_head_wdata    = sbuf[0].data;
            stb_head_sel_byte = sbuf[0].sel;
        end else begin
            stb_head_addr     = '0;
            stb_head_wdata    = '0;
            stb_head_sel_byte = '0;
        end
        dcache2stb_ack = (stb2dcache_req === 1'b1) && ack_after != 0 && (req_run + 1 >= ack_after);
        @(negedge clk);
        req_now = stb2dcache_req;
        popped  = stb_r_en;
        if (req_now === 1'b1) begin
            req_hi++;
            if (prev_req !== 1'b1) rises.push_back(cyc);
            if (expq.size() == 0) check("req_without_entry", 1, 0);
            else begin
                check("addr", stb2dcache_addr, expq[0].addr);
                check("wdata", stb2dcache_wdata, expq[0].data);
                check("sel", stb2dcache_sel_byte, expq[0].sel);
                check("w_en", stb2dcache_w_en, 1);
            end
        end
        if (popped === 1'b1) begin
            pops++;
            if (expq.size() != 0) void'(expq.pop_front());
        end
        if (stb_drain_err === 1'b1 && err_first < 0) err_first = cyc;
        if (flush_done === 1'b1 && fd_first < 0) fd_first = cyc;
        prev_req = req_now;
        @(posedge clk);
        #1;
        cyc++;
        if (popped === 1'b1 && sbuf.size() != 0) void'(sbuf.pop_front());
        req_run = (req_now === 1'b1 && popped !== 1'b1) ? req_run + 1 : 0;
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while ((expq.size() != 0 || stb2dcache_req === 1'b1) && n < bound) begin
            tick();
            n++;
        end
        if (n >= bound) check("drain_bound", 1, 0);
    endtask

    task automatic check_rise(input int i, input int want);
        if (rises.size() > i) check($sformatf("rise%0d", i), rises[i], want);
        else check($sformatf("rise%0d_missing", i), 1, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req"}, stb2dcache_req, 0);
        check({tag, "_w_en"}, stb2dcache_w_en, 0);
        check({tag, "_addr"}, stb2dcache_addr, 0);
        check({tag, "_wdata"}, stb2dcache_wdata, 0);
        check({tag, "_sel"}, stb2dcache_sel_byte, 0);
        check({tag, "_busy"}, stb_drain_busy, 0);
        check({tag, "_err"}, stb_drain_err, 0);
        check({tag, "_r_en"}, stb_r_en, 0);
    endtask

    initial begin
        rst = 1'b1;
        lsu_load_pending = 1'b0;
        flush_req = 1'b0;
        dcache2stb_ack = 1'b0;
        stb_empty = 1'b1;
        stb_head_addr = '0;
        stb_head_wdata = '0;
        stb_head_sel_byte = '0;
        repeat (2) tick();
        check_idle_outputs("reset");
        check("reset_flush_done", flush_done, 0);
        rst = 1'b0;
        tick();

        // Single store, ack on the third request cycle
        new_test();
        ack_after = 3;
        push(32'h1000, 32'hDEADBEEF, 4'hF);
        drain(50);
        check_rise(0, t0 + 1);
        check("single_req_cycles", req_hi, 3);
        check("single_pops", pops, 1);
        check("single_req_after", stb2dcache_req, 0);
        check("single_busy_after", stb_drain_busy, 0);

        // Back-to-back with ack tied high
        new_test();
        ack_after = 1;
        for (int i = 0; i < 4; i++) push(32'h2000 + 32'(i * 4), $urandom, 4'(i + 1));
        drain(50);
        for (int i = 0; i < 4; i++) check_rise(i, t0 + 1 + 2 * i);
        check("b2b_pops", pops, 4);
        check("b2b_busy_after", stb_drain_busy, 0);

        // Load held: full deferral
        new_test();
        lsu_load_pending = 1'b1;
        push(32'h3000, 32'h11112222, 4'h3);
        drain(50);
        check_rise(0, t0 + 9);
        check("defer_pops", pops, 1);

        // Load drops after three cycles
        new_test();
        push(32'h3004, 32'h33334444, 4'hC);
        repeat (3) tick();
        lsu_load_pending = 1'b0;
        drain(50);
        check_rise(0, t0 + 4);

        // Flush overrides load deferral
        new_test();
        lsu_load_pending = 1'b1;
        flush_req = 1'b1;
        ack_after = 2;
        for (int i = 0; i < 3; i++) push(32'h4000 + 32'(i * 8), $urandom, 4'hF);
        drain(50);
        tick();
        for (int i = 0; i < 3; i++) check_rise(i, t0 + 1 + 3 * i);
        check("flush_done_cycle", fd_first, t0 + 9);
        check("flush_done_level", flush_done, 1);
        flush_req = 1'b0;
        lsu_load_pending = 1'b0;

        // Ack timeout: request held, flag sticky
        new_test();
        ack_after = 0;
        push(32'h5000, 32'hCAFEF00D, 4'h5);
        repeat (71) tick();
        check_rise(0, t0 + 1);
        check("timeout_err_cycle", err_first, t0 + 65);
        check("timeout_req_held", stb2dcache_req, 1);
        check("timeout_busy", stb_drain_busy, 1);
        check("timeout_no_pop", pops, 0);
        ack_after = 1;
        drain(20);
        check("timeout_late_pop", pops, 1);
        check("timeout_err_sticky", stb_drain_err, 1);

        // Reset while waiting for ack
        new_test();
        ack_after = 0;
        push(32'h6000, 32'h0BADC0DE, 4'h9);
        repeat (3) tick();
        check("rst_mid_req_before", stb2dcache_req, 1);
        rst = 1'b1;
        tick();
        check_idle_outputs("rst_mid");
        check("rst_mid_no_pop", pops, 0);
        check("rst_mid_entry_kept", sbuf.size(), 1);
        rst = 1'b0;
        req_run = 0;
        ack_after = 1;
        drain(20);
        check("rst_mid_redrain_pop", pops, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
